// File: rtl/xs3_pkg.sv
// Shared types and constants for the serial BCD <-> Excess-3 converter.
// Optional digit validity checking is enabled by defining XS3_CHECK_EN.
package xs3_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } xs3_state_t;

    localparam logic [3:0] XS3_OFFSET   = 4'd3;
    localparam logic       MODE_BCD2XS3 = 1'b0;
    localparam logic       MODE_XS32BCD = 1'b1;
    localparam logic [3:0] BCD_MAX      = 4'd9;
    localparam logic [3:0] XS3_MIN      = 4'd3;
    localparam logic [3:0] XS3_MAX      = 4'd12;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit BCD <-> XS3 converter, purely combinational.
// With XS3_CHECK_EN defined, out-of-range digits are flagged and forced to 4'hF.
module xs3_digit_conv
    import xs3_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       mode,
    output logic [3:0] digit_out,
    output logic       invalid
);

    logic [3:0] sum;

    always_comb begin
        // Per-digit modulo-16 arithmetic; carry/borrow is intentionally dropped.
        if (mode == MODE_XS32BCD) begin
            sum = digit_in - XS3_OFFSET;
        end else begin
            sum = digit_in + XS3_OFFSET;
        end
`ifdef XS3_CHECK_EN
        if (mode == MODE_BCD2XS3) begin
            invalid = (digit_in > BCD_MAX);
        end else begin
            invalid = (digit_in < XS3_MIN) || (digit_in > XS3_MAX);
        end
        digit_out = invalid ? 4'hF : sum;
`else
        invalid   = 1'b0;
        digit_out = sum;
`endif
    end

endmodule

// File: rtl/bcd_xs3_serial_conv.sv
// Multi-digit BCD <-> XS3 converter, one digit per clock LSD first, valid/ready on both sides.
// Define XS3_CHECK_EN to flag invalid digits on out_err.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for an input word
//   CONV  | converting digit[idx] each cycle
//   DONE  | out_valid high, result held until out_ready
module bcd_xs3_serial_conv
    import xs3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_mode,
    input  logic [4*DIGITS-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    xs3_state_t      state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [W-1:0]    src_q, src_d;
    logic [W-1:0]    res_q, res_d;
    logic            mode_q, mode_d;
    logic            err_q, err_d;

    logic [3:0]      digit_sel;
    logic [3:0]      digit_res;
    logic            digit_bad;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = CONV;
            CONV:    if (idx_q == LAST_IDX)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // One shared converter; idx selects which digit it sees this cycle.
    always_comb begin
        digit_sel = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDXW'(i)) begin
                digit_sel = src_q[i*4 +: 4];
            end
        end
    end

    xs3_digit_conv u_digit_conv (
        .digit_in  (digit_sel),
        .mode      (mode_q),
        .digit_out (digit_res),
        .invalid   (digit_bad)
    );

    always_comb begin
        idx_d  = idx_q;
        src_d  = src_q;
        res_d  = res_q;
        mode_d = mode_q;
        err_d  = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    src_d  = in_data;
                    mode_d = in_mode;
                    res_d  = '0;
                    err_d  = 1'b0;
                    idx_d  = '0;
                end
            end
            CONV: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (idx_q == IDXW'(i)) begin
                        res_d[i*4 +: 4] = digit_res;
                    end
                end
                err_d = err_q | digit_bad;
                idx_d = idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q  <= '0;
            src_q  <= '0;
            res_q  <= '0;
            mode_q <= MODE_BCD2XS3;
            err_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            src_q  <= src_d;
            res_q  <= res_d;
            mode_q <= mode_d;
            err_q  <= err_d;
        end
    end

    assign out_data = res_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_bcd_xs3_serial_conv.sv
// Bench for bcd_xs3_serial_conv: a 4-digit and a 1-digit instance against a handshake-level model.
module tb_bcd_xs3_serial_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_err;
    logic [15:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_err;
    logic [3:0]  b_in_data, b_out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    bcd_xs3_serial_conv #(.DIGITS(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_err(a_out_err)
    );

    bcd_xs3_serial_conv #(.DIGITS(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_err(b_out_err)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference conversion: {err, result} for an n-digit word.
    function automatic logic [16:0] ref_conv(input logic [15:0] d, input logic m, input int n);
        logic [15:0] r;
        logic        e;
        logic [3:0]  dg, v;
        logic        bad;
        r = '0;
        e = 1'b0;
        for (int i = 0; i < n; i++) begin
            dg  = d[i*4 +: 4];
            v   = m ? 4'(dg - 4'd3) : 4'(dg + 4'd3);
            bad = m ? ((dg < 4'd3) || (dg > 4'd12)) : (dg > 4'd9);
`ifdef XS3_CHECK_EN
            if (bad) begin
                v = 4'hF;
                e = 1'b1;
            end
`else
            bad = 1'b0;
            e   = e | bad;
`endif
            r[i*4 +: 4] = v;
        end
        return {e, r};
    endfunction

    bit          ma_busy = 1'b0;
    int          ma_left = 0;
    logic [16:0] ma_exp  = '0;
    bit          mb_busy = 1'b0;
    int          mb_left = 0;
    logic [16:0] mb_exp  = '0;

    always @(posedge clk) begin
        if (rst) begin
            ma_busy = 1'b0; ma_left = 0;
            mb_busy = 1'b0; mb_left = 0;
        end else begin
            if (!ma_busy) begin
                if (a_in_valid) begin
                    ma_busy = 1'b1; ma_left = 4;
                    ma_exp  = ref_conv(a_in_data, a_in_mode, 4);
                end
            end else if (ma_left > 0) ma_left--;
            else if (a_out_ready) ma_busy = 1'b0;

            if (!mb_busy) begin
                if (b_in_valid) begin
                    mb_busy = 1'b1; mb_left = 1;
                    mb_exp  = ref_conv({12'h000, b_in_data}, b_in_mode, 1);
                end
            end else if (mb_left > 0) mb_left--;
            else if (b_out_ready) mb_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("a_in_ready", a_in_ready, !ma_busy);
            check("a_out_valid", a_out_valid, ma_busy && ma_left == 0);
            if (ma_busy && ma_left == 0) begin
                check("a_out_data", a_out_data, ma_exp[15:0]);
                check("a_out_err", a_out_err, ma_exp[16]);
            end
            check("b_in_ready", b_in_ready, !mb_busy);
            check("b_out_valid", b_out_valid, mb_busy && mb_left == 0);
            if (mb_busy && mb_left == 0) begin
                check("b_out_data", b_out_data, mb_exp[3:0]);
                check("b_out_err", b_out_err, mb_exp[16]);
            end
        end
    end

    task automatic send_a(input logic [15:0] d, input logic m, input bit keep, output int acc);
        bit ok = 1'b0;
        acc = -1;
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
        for (int i = 0; i < 50; i++) begin
            if (a_in_ready) begin
                @(posedge clk); #1;
                acc = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("a_accept_timeout", 0, 1);
        if (!keep) a_in_valid = 1'b0;
    endtask

    task automatic wait_valid_a(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (a_out_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        if (!a_out_valid) check("a_valid_timeout", 0, 1);
    endtask

    task automatic take_a();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic accept_b(output int acc);
        bit ok = 1'b0;
        acc = -1;
        for (int i = 0; i < 50; i++) begin
            if (b_in_ready) begin
                @(posedge clk); #1;
                acc = cyc; ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("b_accept_timeout", 0, 1);
    endtask

    initial begin
        int t, t2, lat;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_mode = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 16'h0000);
        check("rst_out_err", a_out_err, 0);

        // Encode with latency check
        send_a(16'h1959, 1'b0, 1'b0, t);
        wait_valid_a(lat);
        check("enc_latency", lat, 4);
        check("enc_data", a_out_data, 16'h4C8C);
        check("enc_err", a_out_err, 0);
        take_a();

        // Decode
        send_a(16'h4C8C, 1'b1, 1'b0, t);
        wait_valid_a(lat);
        check("dec_data", a_out_data, 16'h1959);
        take_a();
        send_a(16'h3333, 1'b1, 1'b0, t);
        wait_valid_a(lat);
        check("dec_zero", a_out_data, 16'h0000);
        take_a();

        // Invalid digit
        send_a(16'h00A0, 1'b0, 1'b0, t);
        wait_valid_a(lat);
`ifdef XS3_CHECK_EN
        check("inv_data", a_out_data, 16'h33F3);
        check("inv_err", a_out_err, 1);
`else
        check("inv_data", a_out_data, 16'h33D3);
        check("inv_err", a_out_err, 0);
`endif
        take_a();

        // Backpressure with a second word waiting
        send_a(16'h0123, 1'b0, 1'b1, t);
        a_in_data = 16'h9876; a_in_mode = 1'b1;
        wait_valid_a(lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_valid", a_out_valid, 1);
            check("bp_data", a_out_data, 16'h3456);
            check("bp_in_ready", a_in_ready, 0);
        end
        take_a();
        check("bp_idle_ready", a_in_ready, 1);
        @(posedge clk); #1;
        check("bp_second_accepted", a_in_ready, 0);
        a_in_valid = 1'b0;
        wait_valid_a(lat);
        check("bp_second_latency", lat, 4);
        check("bp_second_data", a_out_data, 16'h6543);
        take_a();

        // Reset in the middle of conversion
        send_a(16'h1234, 1'b0, 1'b0, t);
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_in_ready", a_in_ready, 1);
        check("midrst_out_valid", a_out_valid, 0);
        check("midrst_out_data", a_out_data, 16'h0000);
        rst = 1'b0;
        send_a(16'h0007, 1'b0, 1'b0, t);
        wait_valid_a(lat);
        check("postrst_data", a_out_data, 16'h333A);
        take_a();

        // Single-digit instance, back to back with out_ready held high
        @(negedge clk);
        b_in_valid = 1'b1; b_in_data = 4'h9; b_in_mode = 1'b0;
        accept_b(t);
        @(negedge clk);
        b_in_data = 4'hC; b_in_mode = 1'b1;
        @(posedge clk); #1;
        check("d1_valid_first", b_out_valid, 1);
        check("d1_data_first", b_out_data, 4'hC);
        @(negedge clk);
        accept_b(t2);
        check("d1_spacing", t2 - t, 3);
        b_in_valid = 1'b0;
        @(posedge clk); #1;
        check("d1_valid_second", b_out_valid, 1);
        check("d1_data_second", b_out_data, 4'h9);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
